// File: rtl/pipe_latch_chain_pkg.sv
// Shared definitions for the pipeline latch chain: NOP encoding, stage
// indices, per-stage update selection and a saturating increment helper.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned IF_ID  = 32'd0;
  localparam int unsigned ID_EX  = 32'd1;
  localparam int unsigned EX_MEM = 32'd2;
  localparam int unsigned MEM_WB = 32'd3;

  localparam int unsigned SAT_MAX_W = 32'd64;

  typedef enum logic [1:0] {
    OP_FLUSH  = 2'd0,
    OP_HOLD   = 2'd1,
    OP_BUBBLE = 2'd2,
    OP_LOAD   = 2'd3
  } stage_op_e;

  // Counters narrower than 64 bits stop at their own all-ones value.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_v;
    if (width >= SAT_MAX_W) begin
      max_v = {64{1'b1}};
    end else begin
      max_v = (64'd1 << width) - 64'd1;
    end
    if (value >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = value + 64'd1;
    end
  endfunction

endpackage

// File: rtl/pipe_latch_chain_if.sv
// Upstream/downstream handshake bundle of the pipeline latch chain.
interface pipe_latch_chain_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_latch_chain_stage.sv
// One valid+payload pipeline register: flush beats hold, hold beats an
// upstream bubble, otherwise the source is loaded (NOP when invalid).
module pipe_latch_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_INSTR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             hold,
  input  logic             hold_up,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             valid_next
);

  stage_op_e        op_s;
  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic             valid_nxt_s;
  logic [WIDTH-1:0] data_nxt_s;

  // rule selection
  always_comb begin
    op_s = OP_LOAD;
    if (flush) begin
      op_s = OP_FLUSH;
    end else if (hold) begin
      op_s = OP_HOLD;
    end else if (hold_up) begin
      op_s = OP_BUBBLE;
    end else begin
      op_s = OP_LOAD;
    end
  end

  // next register contents for the selected rule
  always_comb begin
    valid_nxt_s = 1'b0;
    data_nxt_s  = NOP_VALUE;
    case (op_s)
      OP_FLUSH, OP_BUBBLE: begin
        valid_nxt_s = 1'b0;
        data_nxt_s  = NOP_VALUE;
      end
      OP_HOLD: begin
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
      end
      OP_LOAD: begin
        valid_nxt_s = src_valid;
        data_nxt_s  = src_valid ? src_data : NOP_VALUE;
      end
      default: begin
        valid_nxt_s = 1'b0;
        data_nxt_s  = NOP_VALUE;
      end
    endcase
  end

  // stage register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= NOP_VALUE;
    end else begin
      valid_r <= valid_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  assign valid      = valid_r;
  assign data       = data_r;
  assign valid_next = valid_nxt_s;

endmodule

// File: rtl/pipe_latch_chain.sv
// Generic chain of DEPTH pipeline latches with per-stage stall/flush.
// Performance counters are built only when PIPE_LATCH_PERF_EN is defined.
module pipe_latch_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_INSTR),
  parameter int unsigned      CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  pipe_latch_chain_if.slave          bus,
  input  logic [DEPTH-1:0]           stall,
  input  logic [DEPTH-1:0]           flush,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [CNT_W-1:0]           bubble_cycles,
  output logic [CNT_W-1:0]           flush_events
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] hold_s;
  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] valid_nxt_s;
  logic [WIDTH-1:0] data_s [DEPTH];
  logic [OCC_W-1:0] occ_nxt_s;
  logic [OCC_W-1:0] occ_r;

  // a stalled stage freezes itself and everything upstream of it
  always_comb begin
    hold_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hold_s[i] = |(stall >> i);
    end
  end

  assign bus.in_ready = ~hold_s[0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             src_valid_s;
    logic [WIDTH-1:0] src_data_s;
    logic             hold_up_s;

    if (g == 0) begin : g_head
      assign src_valid_s = bus.in_valid;
      assign src_data_s  = bus.in_data;
      assign hold_up_s   = 1'b0;
    end else begin : g_body
      assign src_valid_s = valid_s[g-1];
      assign src_data_s  = data_s[g-1];
      assign hold_up_s   = hold_s[g-1];
    end

    pipe_latch_stage #(
      .WIDTH     (WIDTH),
      .NOP_VALUE (NOP_VALUE)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush[g]),
      .hold       (hold_s[g]),
      .hold_up    (hold_up_s),
      .src_valid  (src_valid_s),
      .src_data   (src_data_s),
      .valid      (valid_s[g]),
      .data       (data_s[g]),
      .valid_next (valid_nxt_s[g])
    );
  end

  // popcount of the valid bits the stages are about to load
  always_comb begin
    occ_nxt_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt_s = occ_nxt_s + OCC_W'(valid_nxt_s[i]);
    end
  end

  // occupancy register, kept in step with the stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_r <= '0;
    end else begin
      occ_r <= occ_nxt_s;
    end
  end

  assign bus.out_valid = valid_s[DEPTH-1];
  assign bus.out_data  = data_s[DEPTH-1];
  assign stage_valid   = valid_s;
  assign occupancy     = occ_r;

`ifdef PIPE_LATCH_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] stall_cnt_nxt_s;
  logic [CNT_W-1:0] bubble_cnt_nxt_s;
  logic [CNT_W-1:0] flush_cnt_nxt_s;

  // saturating counter updates
  always_comb begin
    stall_cnt_nxt_s  = stall_cnt_r;
    bubble_cnt_nxt_s = bubble_cnt_r;
    flush_cnt_nxt_s  = flush_cnt_r;
    if (hold_s[0]) begin
      stall_cnt_nxt_s = CNT_W'(sat_inc(64'(stall_cnt_r), CNT_W));
    end else begin
      stall_cnt_nxt_s = stall_cnt_r;
    end
    if (!valid_s[DEPTH-1]) begin
      bubble_cnt_nxt_s = CNT_W'(sat_inc(64'(bubble_cnt_r), CNT_W));
    end else begin
      bubble_cnt_nxt_s = bubble_cnt_r;
    end
    if (|flush) begin
      flush_cnt_nxt_s = CNT_W'(sat_inc(64'(flush_cnt_r), CNT_W));
    end else begin
      flush_cnt_nxt_s = flush_cnt_r;
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r  <= '0;
      bubble_cnt_r <= '0;
      flush_cnt_r  <= '0;
    end else begin
      stall_cnt_r  <= stall_cnt_nxt_s;
      bubble_cnt_r <= bubble_cnt_nxt_s;
      flush_cnt_r  <= flush_cnt_nxt_s;
    end
  end

  assign stall_cycles  = stall_cnt_r;
  assign bubble_cycles = bubble_cnt_r;
  assign flush_events  = flush_cnt_r;
`else
  assign stall_cycles  = '0;
  assign bubble_cycles = '0;
  assign flush_events  = '0;
`endif

endmodule

// File: doc/pipe_latch_chain.md
Name: pipe_latch_chain

Overview:
- Parametrised successor of the single-purpose inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One generic chain of DEPTH pipeline registers carrying a WIDTH-bit payload plus a valid bit per stage.
- Per-stage stall (hold) and flush (bubble) control, with NOP insertion.
- The datapath instantiates it once per boundary (DEPTH=1), or once for a multi-cycle unit (DEPTH>1).

Parameters:
- WIDTH, 32, payload bits per stage.
- DEPTH, 1, number of register stages (>=1); stage 0 is nearest the input.
- NOP_VALUE, 0, payload loaded into an invalid/flushed stage (32'h0 = sll r0,r0,0).
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream stage presents a valid payload.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  chain accepts in_data this cycle.
- stall  in  DEPTH  stall[i] requests stage i to hold.
- flush  in  DEPTH  flush[i] kills the content of stage i.
- out_valid  out  1  valid bit of stage DEPTH-1.
- out_data  out  WIDTH  payload of stage DEPTH-1.
- stage_valid  out  DEPTH  valid bit of every stage.
- occupancy  out  $clog2(DEPTH+1)  count of valid stages.
- stall_cycles  out  CNT_W  performance counter (see Optional Feature).
- bubble_cycles  out  CNT_W  performance counter.
- flush_events  out  CNT_W  performance counter.

Behaviour:
- Reset (clk edge with reset=1): all valid=0, all payload=NOP_VALUE, counters=0. Reset wins over stall/flush/in_valid, including mid-stall.
- Outputs are registered (except in_ready, which is combinational). Latency is DEPTH cycles from acceptance to out_valid when there are no stalls.
- hold[i] = OR of stall[j] for j>=i. A stalled stage freezes every upstream stage.
- in_ready = ~hold[0].
- Per stage i, evaluated on each clk edge, in priority order:
  1. flush[i]=1: valid[i]<=0, data[i]<=NOP_VALUE (overrides hold).
  2. hold[i]=1: keep valid[i] and data[i].
  3. i=0: valid<=in_valid, data<= in_valid ? in_data : NOP_VALUE.
  4. i>0 and hold[i-1]=1: bubble, so valid<=0, data<=NOP_VALUE.
  5. Otherwise: valid/data <= valid/data of stage i-1.
- Payload of an invalid stage always equals NOP_VALUE, so downstream decode sees a harmless instruction.
- The last stage has no downstream back-pressure: out_valid is consumed every cycle unless stall[DEPTH-1]=1.
- in_valid while in_ready=0: input is not captured. The upstream source holds it; the chain does not buffer.
- Flush and stall on the same stage in the same cycle: flush wins, the stage becomes a held bubble, and upstream stages still hold.
- Occupancy is popcount(valid), updated with the registers.
- DEPTH=1 is exactly a classic IF/ID-style latch with stall and flush.

Optional Feature:
- Macro PIPE_LATCH_PERF_EN.
- Defined: three saturating CNT_W counters, cleared by reset.
  - stall_cycles increments on each cycle where hold[0]=1.
  - bubble_cycles increments on each cycle where out_valid=0.
  - flush_events increments by 1 on each cycle where flush!=0.
  - Each counter saturates at all-ones, with no wrap.
- Not defined: the ports remain and are tied to 0, and no counter flops are generated.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INSTR constant (32'h0000_0000).
  - Stage index localparams (IF_ID=0, ID_EX, EX_MEM, MEM_WB).
  - Saturating-increment function.
- One natural sub-module, pipe_latch_stage: a single valid+payload register implementing priority rules 1–5. The chain is a generate loop of DEPTH instances plus the hold OR-reduction.

Test Plan:
- DEPTH=3, stall=0, flush=0. Feed in_data 0x11, 0x22, 0x33 on consecutive cycles with in_valid=1 -> out_data shows 0x11, 0x22, 0x33 at cycles 3, 4, 5 with out_valid=1; occupancy reaches 3.
- DEPTH=3, chain full with A, B, C (stage 0..2). Assert stall[1] for 2 cycles -> stages 0 and 1 hold, in_ready=0, stage 2 gets NOP_VALUE with valid=0 for 2 cycles. Release -> B then A emerge, nothing lost.
- DEPTH=2, flush[0] and flush[1] asserted together for 1 cycle while full -> both valid=0, both payloads 0x0, occupancy=0 on the next cycle.
- DEPTH=2, stall[1]=1 and flush[1]=1 in the same cycle -> stage 1 becomes a bubble, stage 0 holds, in_ready=0.
- Reset asserted for 1 cycle mid-stall with the chain full -> all valid=0, payloads NOP_VALUE, counters 0, in_ready=1 once stall is released.
- With PIPE_LATCH_PERF_EN and CNT_W=4: hold stall[0]=1 for 20 cycles -> stall_cycles saturates at 15. Without the macro, all counters read 0.
